column_bank: RTL and testbench

COLUMN_BANK -- requirements
Module: column_bank

---
 rtl/column_bank_if.sv | 29 ++
 rtl/column_bank.sv | 166 ++++++++++++++++
 tb/tb_column_bank.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/column_bank_if.sv
// column_bank_if: groups the play-control inputs and the column/score
// outputs of column_bank into one bundle.
//   start, finished : game control levels (driven by the game logic)
//   colX, colY      : packed per-column right-edge x / gap-centre y, 11 bits each
//   passColumn      : one-cycle pulse when a column passes the bird
//   score           : saturating pass count
//   running         : high while scrolling
// Modports: master = game logic side, slave = column_bank side.
interface column_bank_if #(
    parameter int NUM_COLS = 2
);
    logic                     start;
    logic                     finished;
    logic [NUM_COLS*11-1:0]   colX;
    logic [NUM_COLS*11-1:0]   colY;
    logic                     passColumn;
    logic [9:0]               score;
    logic                     running;

    modport master (
        output start, finished,
        input  colX, colY, passColumn, score, running
    );

    modport slave (
        input  start, finished,
        output colX, colY, passColumn, score, running
    );
endinterface

// File: rtl/column_bank.sv
// column_bank: a bank of NUM_COLS scrolling obstacle columns for a
// side-scrolling game. Columns move left by SPEED per RUN cycle, respawn at
// the right with a pseudo-random gap height, and each pass of BIRD_X bumps a
// saturating score.
// Ports:
//   gameClk : sole clock, rising edge
//   reset   : synchronous, active-high
//   bus     : column_bank_if slave modport (start, finished in;
//             colX, colY, passColumn, score, running out, all registered)
module column_bank #(
    parameter int          NUM_COLS      = 2,
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          PIPE_WIDTH    = 40,
    parameter int          GAP_HALF      = 50,
    parameter int          PADDING       = 20,
    parameter int          COL_SPACING   = 320,
    parameter int          SPEED         = 1,
    parameter int          BIRD_X        = 160,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic          gameClk,
    input  logic          reset,
    column_bank_if.slave  bus
);

    localparam int X_RESPAWN = SCREEN_WIDTH + 2 * PIPE_WIDTH - 1;
    localparam int Y_MIN     = PADDING + GAP_HALF;
    localparam int Y_RANGE   = SCREEN_HEIGHT - 2 * PADDING - 2 * GAP_HALF;
    localparam int Y_MID     = Y_MIN + Y_RANGE / 2;

    localparam logic [10:0] RESPAWN_X = 11'(X_RESPAWN);
    localparam logic [10:0] SPEED_X   = 11'(SPEED);
    localparam logic [10:0] BIRD_XX   = 11'(BIRD_X);
    localparam logic [10:0] Y_MIN_X   = 11'(Y_MIN);
    localparam logic [10:0] Y_MID_X   = 11'(Y_MID);
    localparam logic [15:0] Y_RANGE_W = 16'(Y_RANGE);

    localparam bit CFG_OK = (NUM_COLS >= 1) && (NUM_COLS <= 8) &&
                            (SPEED >= 1) && (SPEED <= 15) &&
                            (COL_SPACING > SPEED) &&
                            (NUM_COLS * COL_SPACING <= X_RESPAWN + 1) &&
                            (Y_RANGE > 0) && (LFSR_SEED != 16'h0000);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    state_t       state;
    logic [10:0]  col_x  [NUM_COLS];
    logic [10:0]  col_y  [NUM_COLS];
    logic [10:0]  next_x [NUM_COLS];
    logic [10:0]  next_y [NUM_COLS];
    logic [15:0]  lfsr;
    logic [15:0]  lfsr_next;
    logic [10:0]  y_wrap;
    logic         cross_any;
    logic         pass_pending;
    logic         pass_q;
    logic [9:0]   score_q;
    logic         running_q;

    // Columns start evenly spaced, the last one sitting at the respawn point.
    function automatic logic [10:0] init_x(input int unsigned i);
        return 11'(X_RESPAWN - int'(NUM_COLS - 1 - i) * COL_SPACING);
    endfunction

    // Movement, wrap and crossing detection for one RUN tick.
    always_comb begin
        // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        y_wrap    = Y_MIN_X + 11'(lfsr % Y_RANGE_W);
        next_x    = col_x;
        next_y    = col_y;
        cross_any = 1'b0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (col_x[i] >= SPEED_X) begin
                next_x[i] = col_x[i] - SPEED_X;
                if ((col_x[i] >= BIRD_XX) && (next_x[i] < BIRD_XX)) begin
                    cross_any = 1'b1;
                end
            end else begin
                // A respawn is never a pass.
                next_x[i] = RESPAWN_X;
                next_y[i] = y_wrap;
            end
        end
    end

    always_ff @(posedge gameClk) begin
        assert (CFG_OK) else $error("column_bank: inconsistent parameters");
    end

    always_ff @(posedge gameClk) begin
        if (reset) begin
            state        <= IDLE;
            running_q    <= 1'b0;
            pass_q       <= 1'b0;
            pass_pending <= 1'b0;
            score_q      <= '0;
            lfsr         <= LFSR_SEED;
            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                col_x[i] <= init_x(i);
                col_y[i] <= Y_MID_X;
            end
        end else begin
            lfsr         <= lfsr_next;
            pass_q       <= 1'b0;
            pass_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A collision freezes everything, dropping any pass
                    // detected on the previous tick.
                    if (bus.finished) begin
                        state     <= DEAD;
                        running_q <= 1'b0;
                    end else begin
                        col_x        <= next_x;
                        col_y        <= next_y;
                        pass_pending <= cross_any;
                        pass_q       <= pass_pending;
                        if (pass_pending && (score_q != '1)) begin
                            score_q <= score_q + 10'd1;
                        end
                    end
                end
                DEAD: begin
                    // Restart reloads the playfield but keeps the LFSR running.
                    if (bus.start) begin
                        state   <= IDLE;
                        score_q <= '0;
                        for (int unsigned i = 0; i < NUM_COLS; i++) begin
                            col_x[i] <= init_x(i);
                            col_y[i] <= Y_MID_X;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.colX = '0;
        bus.colY = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            bus.colX[11*i +: 11] = col_x[i];
            bus.colY[11*i +: 11] = col_y[i];
        end
        bus.passColumn = pass_q;
        bus.score      = score_q;
        bus.running    = running_q;
    end

endmodule

// File: tb/tb_column_bank.sv
// tb_column_bank: directed self-checking bench for column_bank. One instance
// uses default parameters; a second, shrunken instance reaches score
// saturation in a few thousand cycles.
module tb_column_bank;

    logic gameClk;
    logic reset;

    column_bank_if #(.NUM_COLS(2)) bus ();
    column_bank_if #(.NUM_COLS(4)) sbus ();

    column_bank dut (
        .gameClk (gameClk),
        .reset   (reset),
        .bus     (bus)
    );

    column_bank #(
        .NUM_COLS      (4),
        .SCREEN_WIDTH  (16),
        .SCREEN_HEIGHT (20),
        .PIPE_WIDTH    (2),
        .GAP_HALF      (3),
        .PADDING       (2),
        .COL_SPACING   (5),
        .SPEED         (1),
        .BIRD_X        (8),
        .LFSR_SEED     (16'hACE1)
    ) dut_s (
        .gameClk (gameClk),
        .reset   (reset),
        .bus     (sbus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;

    initial gameClk = 1'b0;
    always #5 gameClk = ~gameClk;

    // Reference LFSR: x^16+x^14+x^13+x^11, seed 0xACE1, shifting right.
    always @(posedge gameClk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge gameClk);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.start = 1'b0; bus.finished = 1'b0;
        sbus.start = 1'b0; sbus.finished = 1'b0;
        step(2);
        reset = 1'b0;
        chk("reset_colx0", int'(bus.colX[10:0]), 399);
        chk("reset_colx1", int'(bus.colX[21:11]), 719);
        chk("reset_coly0", int'(bus.colY[10:0]), 240);
        chk("reset_coly1", int'(bus.colY[21:11]), 240);
        chk("reset_score", int'(bus.score), 0);
        chk("reset_pass", int'(bus.passColumn), 0);
        chk("reset_running", int'(bus.running), 0);
        chk("reset_lfsr", int'(dut.lfsr), 16'hACE1);
        chk("reset_s_colx0", int'(sbus.colX[10:0]), 4);
        chk("reset_s_colx3", int'(sbus.colX[43:33]), 19);
    endtask

    task automatic test_start;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("start_running", int'(bus.running), 1);
        chk("start_nomove", int'(bus.colX[10:0]), 399);
        step(10);
        chk("run10_colx0", int'(bus.colX[10:0]), 389);
        chk("run10_colx1", int'(bus.colX[21:11]), 709);
        chk("run10_running", int'(bus.running), 1);
    endtask

    task automatic test_pass;
        step(229);
        chk("pass_at160", int'(bus.colX[10:0]), 160);
        step(1);
        chk("pass_colx159", int'(bus.colX[10:0]), 159);
        chk("pass_not_yet", int'(bus.passColumn), 0);
        step(1);
        chk("pass_pulse", int'(bus.passColumn), 1);
        chk("pass_score", int'(bus.score), 1);
        step(1);
        chk("pass_pulse_end", int'(bus.passColumn), 0);
        chk("pass_score_hold", int'(bus.score), 1);
    endtask

    task automatic test_wrap;
        int exp_y;
        step(157);
        chk("wrap_at0", int'(bus.colX[10:0]), 0);
        exp_y = 70 + int'(m_lfsr % 16'd340);
        step(1);
        chk("wrap_colx", int'(bus.colX[10:0]), 719);
        chk("wrap_coly", int'(bus.colY[10:0]), exp_y);
        checks++;
        if (bus.colY[10:0] < 11'd70 || bus.colY[10:0] > 11'd409) begin
            errors++;
            $display("FAIL wrap_coly_range: got %0d expected 70..409", bus.colY[10:0]);
        end
        chk("wrap_colx1", int'(bus.colX[21:11]), 319);
        chk("wrap_nopass0", int'(bus.passColumn), 0);
        step(1);
        chk("wrap_nopass1", int'(bus.passColumn), 0);
        chk("wrap_score", int'(bus.score), 1);
    endtask

    task automatic test_finished;
        step(158);
        chk("fin_col1_160", int'(bus.colX[21:11]), 160);
        step(1);
        chk("fin_col1_159", int'(bus.colX[21:11]), 159);
        bus.finished = 1'b1;
        step(1);
        bus.finished = 1'b0;
        chk("fin_running", int'(bus.running), 0);
        chk("fin_frozen", int'(bus.colX[21:11]), 159);
        chk("fin_nopass", int'(bus.passColumn), 0);
        chk("fin_score", int'(bus.score), 1);
        step(2);
        chk("dead_frozen", int'(bus.colX[21:11]), 159);
        chk("dead_nopass", int'(bus.passColumn), 0);
        chk("dead_score", int'(bus.score), 1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("restart_colx0", int'(bus.colX[10:0]), 399);
        chk("restart_colx1", int'(bus.colX[21:11]), 719);
        chk("restart_coly0", int'(bus.colY[10:0]), 240);
        chk("restart_score", int'(bus.score), 0);
        chk("restart_running", int'(bus.running), 0);
        chk("restart_lfsr_kept", int'(dut.lfsr), int'(m_lfsr));
        bus.finished = 1'b1;
        step(1);
        bus.finished = 1'b0;
        chk("idle_ignores_fin", int'(bus.running), 0);
        chk("idle_hold_colx0", int'(bus.colX[10:0]), 399);
    endtask

    task automatic test_reset_mid_run;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(362);
        chk("mid_colx0_37", int'(bus.colX[10:0]), 37);
        chk("mid_score", int'(bus.score), 1);
        reset = 1'b1; bus.start = 1'b1; bus.finished = 1'b1;
        step(1);
        reset = 1'b0; bus.start = 1'b0; bus.finished = 1'b0;
        chk("rst_colx0", int'(bus.colX[10:0]), 399);
        chk("rst_colx1", int'(bus.colX[21:11]), 719);
        chk("rst_coly0", int'(bus.colY[10:0]), 240);
        chk("rst_coly1", int'(bus.colY[21:11]), 240);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_score", int'(bus.score), 0);
        chk("rst_lfsr", int'(dut.lfsr), 16'hACE1);
        step(1);
        chk("rst_stays_idle", int'(bus.colX[10:0]), 399);
    endtask

    task automatic test_saturation;
        int c;
        sbus.start = 1'b1;
        step(1);
        sbus.start = 1'b0;
        c = 0;
        while (c < 6000 && sbus.score != 10'd1022) begin
            step(1);
            c++;
        end
        chk("sat_reach_1022", int'(sbus.score), 1022);
        for (int k = 0; k < 2; k++) begin
            step(1);
            c = 0;
            while (c < 20 && sbus.passColumn != 1'b1) begin
                step(1);
                c++;
            end
            chk($sformatf("sat_pulse%0d", k), int'(sbus.passColumn), 1);
            chk($sformatf("sat_score%0d", k), int'(sbus.score), 1023);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pass();
        test_wrap();
        test_finished();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
